// File: rtl/eim_sys_request_handler.sv
// System-clock-side request executor for the EIM bridge: buffers forwarded requests,
// drives single-cycle core bus strobes and paces read responses to the return CDC.
module eim_sys_request_handler #(
  parameter int ADDR_WIDTH   = 17,
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 2,
  parameter int RESP_GAP     = 4
) (
  input  logic                             sys_clk,
  input  logic                             sys_rst,
  input  logic [ADDR_WIDTH+DATA_WIDTH:0]   req_din,
  input  logic                             req_pulse,
  output logic [ADDR_WIDTH-1:0]            sys_addr,
  output logic                             sys_wr_en,
  output logic                             sys_rd_en,
  output logic [DATA_WIDTH-1:0]            sys_write_data,
  input  logic [DATA_WIDTH-1:0]            sys_read_data,
  output logic [DATA_WIDTH-1:0]            resp_dout,
  output logic                             resp_req,
  output logic                             busy,
  output logic                             overflow
);

  localparam int REQ_W = 1 + ADDR_WIDTH + DATA_WIDTH;
  localparam logic [3:0] LAT_INIT = 4'(READ_LATENCY);
  localparam logic [3:0] GAP_INIT = 4'(RESP_GAP);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t                state;
  logic [REQ_W-1:0]      fifo_mem [2];
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic [1:0]            count;
  logic [1:0]            count_nxt;
  logic                  pop;
  logic                  push_ok;
  logic [REQ_W-1:0]      head;
  logic                  we_q;
  logic [3:0]            lat_cnt;
  logic [3:0]            gap_cnt;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  fire;
  logic                  to_idle;

  always_comb begin
    pop       = (state == IDLE) && (count != 2'd0);
    push_ok   = req_pulse && ((count != 2'd2) || pop);
    count_nxt = count + {1'b0, push_ok} - {1'b0, pop};
    head      = fifo_mem[rd_ptr];
  end

  // The response pulse is registered, so it is launched on the edge that ends the
  // last WAIT cycle when the gap already allows it; RESP only holds a delayed one.
  always_comb begin
    fire = (gap_cnt == 4'd0) &&
           (((state == WAIT) && (lat_cnt == 4'd1)) || (state == RESP));
    to_idle = 1'b0;
    case (state)
      IDLE:    to_idle = (count == 2'd0);
      ISSUE:   to_idle = we_q;
      WAIT:    to_idle = fire;
      RESP:    to_idle = fire;
      default: to_idle = 1'b1;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (push_ok) fifo_mem[wr_ptr] <= req_din;
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= ~wr_ptr;
      if (pop)     rd_ptr <= ~rd_ptr;
      count <= count_nxt;
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state          <= IDLE;
      sys_addr       <= '0;
      sys_write_data <= '0;
      sys_wr_en      <= 1'b0;
      sys_rd_en      <= 1'b0;
      resp_dout      <= '0;
      resp_req       <= 1'b0;
      busy           <= 1'b0;
      overflow       <= 1'b0;
      we_q           <= 1'b0;
      lat_cnt        <= '0;
      gap_cnt        <= '0;
      rdata          <= '0;
    end else begin
      sys_wr_en <= 1'b0;
      sys_rd_en <= 1'b0;
      resp_req  <= 1'b0;
      busy      <= !to_idle || (count_nxt != 2'd0);
      if (req_pulse && !push_ok) overflow <= 1'b1;

      if (fire) begin
        gap_cnt   <= GAP_INIT;
        resp_req  <= 1'b1;
        resp_dout <= (state == WAIT) ? sys_read_data : rdata;
      end else if (gap_cnt != 4'd0) begin
        gap_cnt <= gap_cnt - 4'd1;
      end

      case (state)
        IDLE: begin
          if (pop) begin
            we_q           <= head[REQ_W-1];
            sys_addr       <= head[ADDR_WIDTH+DATA_WIDTH-1 -: ADDR_WIDTH];
            sys_write_data <= head[DATA_WIDTH-1:0];
            sys_wr_en      <= head[REQ_W-1];
            sys_rd_en      <= ~head[REQ_W-1];
            state          <= ISSUE;
          end
        end
        ISSUE: begin
          if (we_q) begin
            state <= IDLE;
          end else begin
            lat_cnt <= LAT_INIT;
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (lat_cnt == 4'd1) begin
            rdata <= sys_read_data;
            state <= fire ? IDLE : RESP;
          end else begin
            lat_cnt <= lat_cnt - 4'd1;
          end
        end
        RESP: begin
          if (fire) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eim_sys_request_handler.sv
// Directed bench for eim_sys_request_handler: write, read, back-to-back reads,
// FIFO full/overflow handling and asynchronous reset mid-read.
module tb_eim_sys_request_handler;

  localparam int AW = 17;
  localparam int DW = 32;
  localparam int READ_LAT = 2;

  logic              sys_clk = 1'b0;
  logic              sys_rst;
  logic [AW+DW:0]    req_din;
  logic              req_pulse;
  logic [AW-1:0]     sys_addr;
  logic              sys_wr_en;
  logic              sys_rd_en;
  logic [DW-1:0]     sys_write_data;
  logic [DW-1:0]     sys_read_data;
  logic [DW-1:0]     resp_dout;
  logic              resp_req;
  logic              busy;
  logic              overflow;

  eim_sys_request_handler #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(READ_LAT), .RESP_GAP(4)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .req_din(req_din), .req_pulse(req_pulse),
    .sys_addr(sys_addr), .sys_wr_en(sys_wr_en), .sys_rd_en(sys_rd_en),
    .sys_write_data(sys_write_data), .sys_read_data(sys_read_data),
    .resp_dout(resp_dout), .resp_req(resp_req), .busy(busy), .overflow(overflow)
  );

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] core_val(input logic [AW-1:0] a);
    return (a == 17'h00020) ? 32'hCAFEF00D : {8'hA5, 7'h00, a};
  endfunction

  // Core model: data is valid only in the cycle READ_LAT after the read strobe.
  logic [3:0]    rd_age = '0;
  logic [AW-1:0] rd_addr = '0;
  always @(posedge sys_clk) begin
    if (sys_rd_en) begin
      rd_age  <= 4'd1;
      rd_addr <= sys_addr;
    end else if (rd_age != 4'd0 && rd_age != 4'd15) begin
      rd_age <= rd_age + 4'd1;
    end
  end
  assign sys_read_data = (rd_age == 4'(READ_LAT)) ? core_val(rd_addr) : 32'hBAD0BAD0;

  int            resp_cyc[$];
  logic [DW-1:0] resp_val[$];
  int            wr_cyc[$];
  logic [AW-1:0] wr_addr[$];
  logic [DW-1:0] wr_data[$];
  logic both_err = 1'b0, dbl_err = 1'b0, prev_wr = 1'b0, prev_rd = 1'b0;

  always @(negedge sys_clk) begin
    if (!sys_rst) begin
      if (resp_req) begin
        resp_cyc.push_back(cyc);
        resp_val.push_back(resp_dout);
      end
      if (sys_wr_en) begin
        wr_cyc.push_back(cyc);
        wr_addr.push_back(sys_addr);
        wr_data.push_back(sys_write_data);
      end
      if (sys_wr_en && sys_rd_en) both_err = 1'b1;
      if ((sys_wr_en && prev_wr) || (sys_rd_en && prev_rd)) dbl_err = 1'b1;
      prev_wr = sys_wr_en;
      prev_rd = sys_rd_en;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic send(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_din   = {we, a, d};
    req_pulse = 1'b1;
    tick();
    req_pulse = 1'b0;
  endtask

  task automatic clear_logs();
    resp_cyc.delete(); resp_val.delete();
    wr_cyc.delete(); wr_addr.delete(); wr_data.delete();
  endtask

  int t0;

  initial begin
    sys_rst   = 1'b1;
    req_pulse = 1'b0;
    req_din   = '0;
    repeat (3) tick();
    chk("rst_addr", 64'(sys_addr), 64'h0);
    chk("rst_wr_en", 64'(sys_wr_en), 64'h0);
    chk("rst_rd_en", 64'(sys_rd_en), 64'h0);
    chk("rst_wdata", 64'(sys_write_data), 64'h0);
    chk("rst_resp_dout", 64'(resp_dout), 64'h0);
    chk("rst_resp_req", 64'(resp_req), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_overflow", 64'(overflow), 64'h0);
    sys_rst = 1'b0;
    repeat (3) tick();

    // single write
    clear_logs();
    send(1'b1, 17'h00010, 32'hDEADBEEF);
    chk("wr_busy_n1", 64'(busy), 64'h1);
    chk("wr_strobe_n1", 64'(sys_wr_en), 64'h0);
    tick();
    chk("wr_strobe_n2", 64'(sys_wr_en), 64'h1);
    chk("wr_rd_n2", 64'(sys_rd_en), 64'h0);
    chk("wr_addr", 64'(sys_addr), 64'h00010);
    chk("wr_data", 64'(sys_write_data), 64'hDEADBEEF);
    tick();
    chk("wr_strobe_n3", 64'(sys_wr_en), 64'h0);
    chk("wr_busy_n3", 64'(busy), 64'h0);
    repeat (4) tick();
    chk("wr_no_resp", 64'(resp_cyc.size()), 64'd0);

    // single read
    send(1'b0, 17'h00020, 32'h0);
    tick();
    chk("rd_strobe_n2", 64'(sys_rd_en), 64'h1);
    chk("rd_addr", 64'(sys_addr), 64'h00020);
    tick();
    chk("rd_strobe_n3", 64'(sys_rd_en), 64'h0);
    tick();
    chk("rd_resp_n4", 64'(resp_req), 64'h0);
    tick();
    chk("rd_resp_n5", 64'(resp_req), 64'h1);
    chk("rd_dout_n5", 64'(resp_dout), 64'hCAFEF00D);
    tick();
    chk("rd_resp_n6", 64'(resp_req), 64'h0);
    chk("rd_dout_hold", 64'(resp_dout), 64'hCAFEF00D);
    chk("rd_busy_n6", 64'(busy), 64'h0);
    repeat (8) tick();

    // three back-to-back reads, paced by the response gap
    clear_logs();
    t0 = cyc;
    send(1'b0, 17'h00100, 32'h0);
    send(1'b0, 17'h00200, 32'h0);
    send(1'b0, 17'h00300, 32'h0);
    repeat (20) tick();
    chk("r3_count", 64'(resp_cyc.size()), 64'd3);
    if (resp_cyc.size() == 3) begin
      chk("r3_cyc0", 64'(resp_cyc[0] - t0), 64'd5);
      chk("r3_cyc1", 64'(resp_cyc[1] - t0), 64'd10);
      chk("r3_cyc2", 64'(resp_cyc[2] - t0), 64'd15);
      chk("r3_val0", 64'(resp_val[0]), 64'(core_val(17'h00100)));
      chk("r3_val1", 64'(resp_val[1]), 64'(core_val(17'h00200)));
      chk("r3_val2", 64'(resp_val[2]), 64'(core_val(17'h00300)));
    end
    chk("r3_overflow", 64'(overflow), 64'h0);
    repeat (5) tick();

    // full FIFO with simultaneous push and pop accepts the push
    clear_logs();
    t0 = cyc;
    send(1'b0, 17'h00040, 32'h0);
    repeat (2) tick();
    send(1'b1, 17'h00041, 32'h11111111);
    send(1'b1, 17'h00042, 32'h22222222);
    send(1'b1, 17'h00043, 32'h33333333);
    repeat (12) tick();
    chk("pp_overflow", 64'(overflow), 64'h0);
    chk("pp_resp_count", 64'(resp_cyc.size()), 64'd1);
    chk("pp_wr_count", 64'(wr_cyc.size()), 64'd3);
    if (resp_cyc.size() == 1) begin
      chk("pp_resp_cyc", 64'(resp_cyc[0] - t0), 64'd5);
      chk("pp_resp_val", 64'(resp_val[0]), 64'(core_val(17'h00040)));
    end
    if (wr_cyc.size() == 3) begin
      chk("pp_wr0_cyc", 64'(wr_cyc[0] - t0), 64'd6);
      chk("pp_wr2_cyc", 64'(wr_cyc[2] - t0), 64'd10);
      chk("pp_wr2_addr", 64'(wr_addr[2]), 64'h00043);
      chk("pp_wr2_data", 64'(wr_data[2]), 64'h33333333);
    end
    repeat (5) tick();

    // overflow: fourth write arrives while full with no pop
    clear_logs();
    t0 = cyc;
    send(1'b0, 17'h00050, 32'h0);
    repeat (2) tick();
    send(1'b1, 17'h00051, 32'hAAAA0001);
    send(1'b1, 17'h00052, 32'hAAAA0002);
    send(1'b1, 17'h00053, 32'hAAAA0003);
    chk("ov_before", 64'(overflow), 64'h0);
    send(1'b1, 17'h00054, 32'hAAAA0004);
    chk("ov_set", 64'(overflow), 64'h1);
    repeat (12) tick();
    chk("ov_sticky", 64'(overflow), 64'h1);
    chk("ov_wr_count", 64'(wr_cyc.size()), 64'd3);
    if (wr_cyc.size() == 3) begin
      chk("ov_wr0_addr", 64'(wr_addr[0]), 64'h00051);
      chk("ov_wr1_addr", 64'(wr_addr[1]), 64'h00052);
      chk("ov_wr2_addr", 64'(wr_addr[2]), 64'h00053);
      chk("ov_wr2_cyc", 64'(wr_cyc[2] - t0), 64'd10);
    end
    repeat (5) tick();

    // asynchronous reset during WAIT of a read
    clear_logs();
    send(1'b0, 17'h00070, 32'h0);
    tick();
    chk("ar_rd_strobe", 64'(sys_rd_en), 64'h1);
    tick();
    sys_rst = 1'b1;
    #1;
    chk("ar_addr", 64'(sys_addr), 64'h0);
    chk("ar_resp_dout", 64'(resp_dout), 64'h0);
    chk("ar_busy", 64'(busy), 64'h0);
    chk("ar_overflow", 64'(overflow), 64'h0);
    chk("ar_rd_en", 64'(sys_rd_en), 64'h0);
    tick();
    sys_rst = 1'b0;
    repeat (10) tick();
    chk("ar_no_resp", 64'(resp_cyc.size()), 64'd0);
    send(1'b0, 17'h00080, 32'h0);
    repeat (3) tick();
    chk("ar2_resp_n4", 64'(resp_req), 64'h0);
    tick();
    chk("ar2_resp_n5", 64'(resp_req), 64'h1);
    chk("ar2_dout", 64'(resp_dout), 64'(core_val(17'h00080)));
    repeat (4) tick();

    chk("never_both_strobes", 64'(both_err), 64'h0);
    chk("strobe_single_cycle", 64'(dbl_err), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
